jtdd_sdram_arb: RTL



---
 rtl/jtdd_sdram_arb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jtdd_sdram_arb.sv
// Four-client SDRAM read arbiter with a one-word cache per client.
// Slot 0 (main CPU) has fixed priority; slots 1-3 share the port round-robin.
module jtdd_sdram_arb #(
    parameter int            AW      = 22,
    parameter int            DW      = 32,
    parameter int            TIMEOUT = 64,
    parameter logic [AW-1:0] OFFSET1 = '0,
    parameter logic [AW-1:0] OFFSET2 = '0,
    parameter logic [AW-1:0] OFFSET3 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [4*DW-1:0] slot_dout,
    output logic [3:0]      slot_ok,
    output logic            sdram_req,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [DW-1:0]   data_read,
    output logic [AW-1:0]   sdram_addr
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [AW-1:0] sdram_addr_q, sdram_addr_d;
    logic          sdram_req_q, sdram_req_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    valid_q, valid_d;
    logic [AW-1:0] cache_addr_q [4];
    logic [AW-1:0] cache_addr_d [4];
    logic [DW-1:0] cache_data_q [4];
    logic [DW-1:0] cache_data_d [4];

    logic [3:0]    hit;
    logic [3:0]    miss;
    logic [1:0]    rr_gnt;
    logic          rr_found;
    logic [1:0]    sel;
    logic [AW-1:0] sel_addr;
    logic          fill;

    function automatic logic [AW-1:0] slot_offset(input logic [1:0] s);
        case (s)
            2'd1:    slot_offset = OFFSET1;
            2'd2:    slot_offset = OFFSET2;
            2'd3:    slot_offset = OFFSET3;
            default: slot_offset = '0;
        endcase
    endfunction

    // Hit/miss are purely combinational on the registered cache contents.
    always_comb begin
        hit       = '0;
        slot_dout = '0;
        for (int i = 0; i < 4; i++) begin
            hit[i] = valid_q[i] && (cache_addr_q[i] == slot_addr[i*AW +: AW]);
            slot_dout[i*DW +: DW] = cache_data_q[i];
        end
        miss    = slot_cs & ~hit;
        slot_ok = (rst || downloading) ? 4'd0 : (slot_cs & hit);
    end

    // Round-robin search over slots 1..3 starting at rr_ptr, wrapping 3->1.
    always_comb begin
        logic [2:0] cand;
        rr_found = 1'b0;
        rr_gnt   = 2'd1;
        cand     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, rr_ptr_q} + 3'(i);
            if (cand > 3'd3) cand = cand - 3'd3;
            if (!rr_found && miss[cand[1:0]]) begin
                rr_found = 1'b1;
                rr_gnt   = cand[1:0];
            end
        end
        sel      = miss[0] ? 2'd0 : rr_gnt;
        sel_addr = slot_addr[sel*AW +: AW];
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_ptr_d     = rr_ptr_q;
        lat_addr_d   = lat_addr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        timer_d      = timer_q;
        valid_d      = valid_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
        fill         = 1'b0;

        if (downloading) begin
            // Downloads abort any access and keep every cache entry invalid.
            state_d     = ST_IDLE;
            sdram_req_d = 1'b0;
            timer_d     = '0;
            valid_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|miss) begin
                        gnt_d        = sel;
                        lat_addr_d   = sel_addr;
                        sdram_addr_d = sel_addr + slot_offset(sel);
                        sdram_req_d  = 1'b1;
                        state_d      = ST_REQ;
                        if (!miss[0]) rr_ptr_d = (rr_gnt == 2'd3) ? 2'd1 : rr_gnt + 2'd1;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req_d = 1'b0;
                        timer_d     = '0;
                        if (data_rdy) begin
                            fill    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        fill    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        // Abandon; the slot still misses and is requested again.
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    sdram_req_d = 1'b0;
                end
            endcase

            if (fill) begin
                cache_data_d[gnt_q] = data_read;
                cache_addr_d[gnt_q] = lat_addr_q;
                valid_d[gnt_q]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'd0;
            rr_ptr_q     <= 2'd1;
            lat_addr_q   <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
            timer_q      <= '0;
            valid_q      <= '0;
            cache_addr_q <= '{default: '0};
            cache_data_q <= '{default: '0};
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_addr_q   <= lat_addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
            timer_q      <= timer_d;
            valid_q      <= valid_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

endmodule
